vid_tim_ctrl: RTL and testbench
===============================

# vid_tim_ctrl

Sequencing and configuration controller for a pair of line/frame timing cores: one horizontal instance and one vertical instance. The block holds a register bank behind a simple write port and a divided pixel-rate enable. It starts, stops and single-steps the cores per frame, and hands them double-buffered timing parameters that change only on frame boundaries.

## Interface
Parameters:
- `DIV_W`, default 4: width of the pixel-clock divider field.

Ports:
- `clk`  in  1  master clock.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_we`  in  1  register write strobe.
- `cfg_addr`  in  3  register index.
- `cfg_wdata`  in  16  write data.
- `h_tsync`, `h_tgdel`  out  8 each  active horizontal sync length and gate delay.
- `h_tgate`, `h_tlen`  out  16 each  active horizontal gate length and line length.
- `v_tsync`, `v_tgdel`, `v_tgate`, `v_tlen`  out  8/8/16/16  active vertical parameters.
- `core_clr`  out  1  one-cycle clear to both cores.
- `h_ena`  out  1  horizontal core count enable; equals `pix_ce`.
- `v_ena`  out  1  vertical core count enable.
- `h_done`, `v_done`  in  1 each  line-done and frame-done pulses from the cores.
- `busy`  out  1  high in LOAD, RUN and DRAIN.
- `upd_pend`  out  1  shadow registers hold unapplied writes.
- `frame_irq`  out  1  one-cycle pulse per completed frame.
- `line_cnt`, `frame_cnt`  out  16 each  status counters.

## Operation
Register map (addr : contents):
- 0: CTRL. bit0 `en`, bit1 `single`. Written directly, never shadowed.
- 1: {Thgdel[15:8], Thsync[7:0]}.
- 2: Thgate.
- 3: Thlen.
- 4: {Tvgdel[15:8], Tvsync[7:0]}.
- 5: Tvgate.
- 6: Tvlen.
- 7: pix_div[DIV_W-1:0]; upper bits are ignored.

Shadowing:
- Writes to addr 1–7 update the shadow copy and set `upd_pend`.
- Active copy ← shadow, and `upd_pend` clears, in exactly two cases: the LOAD cycle, and a `v_done` cycle in RUN while `upd_pend`=1.
- A write in the same cycle as an apply: the active copy takes the pre-write shadow, the write lands in the shadow, and `upd_pend` stays 1.

State machine:
- IDLE → LOAD when `en`=1.
- LOAD is one cycle: `core_clr`=1, shadow applied, divider counter cleared, `line_cnt` cleared. Next state is RUN.
- RUN → DRAIN when `en`=0.
- RUN → IDLE on `v_done` when `single`=1; `en` self-clears in that cycle.
- DRAIN → IDLE on `v_done`. Writes to `en` are ignored in DRAIN; the frame always completes.

Pixel enable:
- Divider counter `dc` runs only in RUN and DRAIN.
- `pix_ce`=1 when `dc`==0. `dc` counts 0..pix_div, then wraps to 0.
- pix_div=0 gives `pix_ce` every cycle.

Vertical enable:
- `v_ena` = `h_done` AND (RUN or DRAIN). Combinational, one cycle per line.

Counters:
- `line_cnt` increments on `h_done` (RUN/DRAIN) and clears on `v_done`. On a simultaneous `h_done`/`v_done`, the clear wins.
- `frame_cnt` increments on `v_done` in RUN/DRAIN, wraps at 16'hFFFF→0, and clears only on `rst`.
- `frame_irq` = `v_done` registered, valid in RUN/DRAIN.

Done inputs outside RUN/DRAIN are ignored.

## Timing
- Reset values:
  - state IDLE.
  - All shadow and active registers 0.
  - `en`, `single`, `upd_pend`, `core_clr`, `h_ena`, `v_ena`, `busy`, `frame_irq` = 0.
  - `line_cnt`, `frame_cnt` = 0.
- `rst` mid-operation: returns to IDLE the next cycle and clears all of the above. `core_clr` is not asserted by reset; the cores share `rst` at integration.
- Latency:
  - The write cycle sets `en`; the next cycle is LOAD.
  - The first RUN cycle asserts `h_ena`=1.
- All outputs are registered except `h_ena` and `v_ena`, which are decoded from state/`dc`/`h_done`.
- `busy` deasserts in the cycle after the terminating `v_done`.

## Structure
- Shared package `vid_tim_pkg`:
  - state encoding, one-hot with 4 bits.
  - register address constants `CTRL_A` … `PDIV_A`.
  - bit positions `EN_B` and `SINGLE_B`.
  - a packed timing-parameter struct reused for the shadow and active copies.
- Sub-module `vid_tim_regs`: shadow/active bank with apply logic.
- FSM, divider and counters live in the top level.

## Test plan
- **Basic run:** write Thsync=2, Thgdel=1, Thgate=4, Thlen=10, vertical 1/1/3/6, pix_div=0, then CTRL=1 → `core_clr` one cycle after the write; `h_ena` constant 1; `v_ena` pulses coincide with `h_done`; `frame_irq` once per `v_done`; `frame_cnt` 1,2,3.
- **Divider:** pix_div=3 → `h_ena` high exactly 1 of every 4 cycles, starting on the first RUN cycle.
- **Mid-frame update:** write Thlen=20 during frame 1 → `upd_pend`=1; `h_tlen` stays 10 until the `v_done` of frame 1, then becomes 20 and `upd_pend`=0.
- **Write collides with apply:** write coincident with `v_done` → active takes the old shadow; the new value applies at the next `v_done`.
- **Stop and single-frame:** clear `en` mid-frame → DRAIN, `busy` holds until `v_done`, then IDLE. CTRL=3 → exactly one frame, `en` reads 0 afterwards.
- **Reset and wrap:** `rst` during RUN → all outputs 0 next cycle. Preset `frame_cnt`=16'hFFFF by forcing → next `v_done` gives 0.

Source files
------------

// File: rtl/vid_tim_pkg.sv
// Shared types and constants for the video timing controller.
package vid_tim_pkg;

   // One-hot sequencer states
   typedef enum logic [3:0] {
      StIdle  = 4'b0001,
      StLoad  = 4'b0010,
      StRun   = 4'b0100,
      StDrain = 4'b1000
   } state_e;

   // Register map
   localparam logic [2:0] CTRL_A  = 3'd0;
   localparam logic [2:0] HSYNC_A = 3'd1;
   localparam logic [2:0] HGATE_A = 3'd2;
   localparam logic [2:0] HLEN_A  = 3'd3;
   localparam logic [2:0] VSYNC_A = 3'd4;
   localparam logic [2:0] VGATE_A = 3'd5;
   localparam logic [2:0] VLEN_A  = 3'd6;
   localparam logic [2:0] PDIV_A  = 3'd7;

   // CTRL bit positions
   localparam int unsigned EN_B     = 0;
   localparam int unsigned SINGLE_B = 1;

   // Timing parameters; same layout for the shadow and active copies
   typedef struct packed {
      logic [7:0]  h_tgdel;
      logic [7:0]  h_tsync;
      logic [15:0] h_tgate;
      logic [15:0] h_tlen;
      logic [7:0]  v_tgdel;
      logic [7:0]  v_tsync;
      logic [15:0] v_tgate;
      logic [15:0] v_tlen;
   } tim_par_t;

   // States in which the cores are counting
   function automatic logic is_active(state_e s);
      return (s == StRun) || (s == StDrain);
   endfunction

endpackage

// File: rtl/vid_tim_regs.sv
// Double-buffered timing parameters: writes land in the shadow copy, the
// active copy follows only when the sequencer requests an apply.
module vid_tim_regs
   import vid_tim_pkg::*;
#(
   parameter int unsigned DIV_W = 4  // must not exceed 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [2:0]       addr,
   input  logic [15:0]      wdata,
   input  logic             apply,
   output tim_par_t         act,
   output logic [DIV_W-1:0] act_div,
   output logic             upd_pend
);

   tim_par_t         shd;
   logic [DIV_W-1:0] shd_div;
   logic             par_wr;

   assign par_wr = we && (addr != CTRL_A);

   // Apply copies the pre-write shadow; a colliding write stays pending
   always_ff @(posedge clk) begin
      if (rst) begin
         shd      <= '0;
         shd_div  <= '0;
         act      <= '0;
         act_div  <= '0;
         upd_pend <= 1'b0;
      end else begin
         if (apply) begin
            act      <= shd;
            act_div  <= shd_div;
            upd_pend <= 1'b0;
         end
         if (par_wr) begin
            upd_pend <= 1'b1;
            case (addr)
               HSYNC_A: begin
                  shd.h_tgdel <= wdata[15:8];
                  shd.h_tsync <= wdata[7:0];
               end
               HGATE_A: shd.h_tgate <= wdata;
               HLEN_A:  shd.h_tlen  <= wdata;
               VSYNC_A: begin
                  shd.v_tgdel <= wdata[15:8];
                  shd.v_tsync <= wdata[7:0];
               end
               VGATE_A: shd.v_tgate <= wdata;
               VLEN_A:  shd.v_tlen  <= wdata;
               PDIV_A:  shd_div     <= wdata[DIV_W-1:0];
               default: ;
            endcase
         end
      end
   end

endmodule

// File: rtl/vid_tim_ctrl.sv
// Sequencer for a horizontal/vertical timing core pair: frame-level start,
// stop and single-step, pixel-rate divider, status counters.
module vid_tim_ctrl
   import vid_tim_pkg::*;
#(
   parameter int unsigned DIV_W = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_we,
   input  logic [2:0]  cfg_addr,
   input  logic [15:0] cfg_wdata,
   output logic [7:0]  h_tsync,
   output logic [7:0]  h_tgdel,
   output logic [15:0] h_tgate,
   output logic [15:0] h_tlen,
   output logic [7:0]  v_tsync,
   output logic [7:0]  v_tgdel,
   output logic [15:0] v_tgate,
   output logic [15:0] v_tlen,
   output logic        core_clr,
   output logic        h_ena,
   output logic        v_ena,
   input  logic        h_done,
   input  logic        v_done,
   output logic        busy,
   output logic        upd_pend,
   output logic        frame_irq,
   output logic [15:0] line_cnt,
   output logic [15:0] frame_cnt
);

   state_e           state;
   logic             en;
   logic             en_d;
   logic             single;
   logic [DIV_W-1:0] dc;
   logic [DIV_W-1:0] act_div;
   tim_par_t         act;
   logic             running;
   logic             ctrl_wr;
   logic             apply;

   assign running = is_active(state);
   assign ctrl_wr = cfg_we && (cfg_addr == CTRL_A);
   assign apply   = (state == StLoad) || ((state == StRun) && v_done && upd_pend);

   vid_tim_regs #(
      .DIV_W (DIV_W)
   ) u_regs (
      .clk      (clk),
      .rst      (rst),
      .we       (cfg_we),
      .addr     (cfg_addr),
      .wdata    (cfg_wdata),
      .apply    (apply),
      .act      (act),
      .act_div  (act_div),
      .upd_pend (upd_pend)
   );

   assign h_tsync = act.h_tsync;
   assign h_tgdel = act.h_tgdel;
   assign h_tgate = act.h_tgate;
   assign h_tlen  = act.h_tlen;
   assign v_tsync = act.v_tsync;
   assign v_tgdel = act.v_tgdel;
   assign v_tgate = act.v_tgate;
   assign v_tlen  = act.v_tlen;

   // Pixel enable and per-line vertical enable, decoded from state
   assign h_ena = running && (dc == '0);
   assign v_ena = running && h_done;

   // Next value of en: writes ignored while draining, self-clear ends a single frame
   always_comb begin
      en_d = en;
      if (ctrl_wr && (state != StDrain)) begin
         en_d = cfg_wdata[EN_B];
      end
      if ((state == StRun) && v_done && single) begin
         en_d = 1'b0;
      end
   end

   // Sequencer, divider and status counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= StIdle;
         en        <= 1'b0;
         single    <= 1'b0;
         core_clr  <= 1'b0;
         busy      <= 1'b0;
         frame_irq <= 1'b0;
         line_cnt  <= '0;
         frame_cnt <= '0;
         dc        <= '0;
      end else begin
         en        <= en_d;
         core_clr  <= 1'b0;
         frame_irq <= running && v_done;
         if (ctrl_wr) begin
            single <= cfg_wdata[SINGLE_B];
         end

         unique case (state)
            StIdle: begin
               if (en_d) begin
                  state    <= StLoad;
                  core_clr <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            StLoad: begin
               state    <= StRun;
               dc       <= '0;
               line_cnt <= '0;
            end
            StRun: begin
               if (v_done && single) begin
                  state <= StIdle;
                  busy  <= 1'b0;
               end else if (!en) begin
                  state <= StDrain;
               end
            end
            StDrain: begin
               if (v_done) begin
                  state <= StIdle;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= StIdle;
               busy  <= 1'b0;
            end
         endcase

         if (running) begin
            // >= keeps the wrap safe if the divisor ever shrinks under a running count
            dc <= (dc >= act_div) ? '0 : dc + 1'b1;
            if (v_done) begin
               line_cnt  <= '0;
               frame_cnt <= frame_cnt + 16'd1;
            end else if (h_done) begin
               line_cnt <= line_cnt + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_vid_tim_ctrl.sv
// Self-checking bench for vid_tim_ctrl: directed test-plan steps followed by
// random traffic, all compared against a frame-level behavioural model.
module tb_vid_tim_ctrl;

   localparam int unsigned DIV_W = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_we;
   logic [2:0]  cfg_addr;
   logic [15:0] cfg_wdata;
   logic [7:0]  h_tsync, h_tgdel, v_tsync, v_tgdel;
   logic [15:0] h_tgate, h_tlen, v_tgate, v_tlen;
   logic        core_clr, h_ena, v_ena, h_done, v_done;
   logic        busy, upd_pend, frame_irq;
   logic [15:0] line_cnt, frame_cnt;

   vid_tim_ctrl #(
      .DIV_W (DIV_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .h_tsync   (h_tsync),
      .h_tgdel   (h_tgdel),
      .h_tgate   (h_tgate),
      .h_tlen    (h_tlen),
      .v_tsync   (v_tsync),
      .v_tgdel   (v_tgdel),
      .v_tgate   (v_tgate),
      .v_tlen    (v_tlen),
      .core_clr  (core_clr),
      .h_ena     (h_ena),
      .v_ena     (v_ena),
      .h_done    (h_done),
      .v_done    (v_done),
      .busy      (busy),
      .upd_pend  (upd_pend),
      .frame_irq (frame_irq),
      .line_cnt  (line_cnt),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model: mode 0 idle, 1 load, 2 run, 3 drain
   int          m_mode = 0;
   bit          m_en, m_single, m_pend, m_irq, m_valid;
   logic [15:0] m_sh[8];
   logic [15:0] m_act[8];
   logic [15:0] m_line, m_frame;
   int          m_rc;  // cycles spent counting since the frame sequence started

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         if (n_bad <= 30) $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic bit m_running();
      return m_mode >= 2;
   endfunction

   task automatic model_update(input bit we, input logic [2:0] a, input logic [15:0] d,
                               input bit hd, input bit vd, input bit r);
      bit old_en, old_single, run_now;
      if (r) begin
         m_mode = 0; m_en = 0; m_single = 0; m_pend = 0; m_irq = 0;
         m_line = 0; m_frame = 0; m_rc = 0; m_valid = 1;
         for (int i = 0; i < 8; i++) begin
            m_sh[i] = 0;
            m_act[i] = 0;
         end
         return;
      end
      old_en = m_en;
      old_single = m_single;
      run_now = m_running();
      if (m_mode == 1 || (m_mode == 2 && vd && m_pend)) begin
         m_act = m_sh;
         m_pend = 0;
      end
      if (we && a != 0) begin
         m_sh[a] = d;
         m_pend = 1;
      end
      if (we && a == 0) begin
         if (m_mode != 3) m_en = d[0];
         m_single = d[1];
      end
      m_irq = run_now && vd;
      if (run_now) begin
         if (vd) begin
            m_line = 0;
            m_frame = m_frame + 16'd1;
         end else if (hd) begin
            m_line = m_line + 16'd1;
         end
         m_rc++;
      end
      case (m_mode)
         0: if (m_en) m_mode = 1;
         1: begin m_mode = 2; m_rc = 0; m_line = 0; end
         2: begin
            if (vd && old_single) begin m_mode = 0; m_en = 0; end
            else if (!old_en) m_mode = 3;
         end
         default: if (vd) m_mode = 0;
      endcase
   endtask

   task automatic check_regs();
      chk("core_clr", {15'd0, core_clr}, {15'd0, m_mode == 1});
      chk("busy", {15'd0, busy}, {15'd0, m_mode != 0});
      chk("frame_irq", {15'd0, frame_irq}, {15'd0, m_irq});
      chk("upd_pend", {15'd0, upd_pend}, {15'd0, m_pend});
      chk("line_cnt", line_cnt, m_line);
      chk("frame_cnt", frame_cnt, m_frame);
      chk("h_tsync", {8'd0, h_tsync}, {8'd0, m_act[1][7:0]});
      chk("h_tgdel", {8'd0, h_tgdel}, {8'd0, m_act[1][15:8]});
      chk("h_tgate", h_tgate, m_act[2]);
      chk("h_tlen", h_tlen, m_act[3]);
      chk("v_tsync", {8'd0, v_tsync}, {8'd0, m_act[4][7:0]});
      chk("v_tgdel", {8'd0, v_tgdel}, {8'd0, m_act[4][15:8]});
      chk("v_tgate", v_tgate, m_act[5]);
      chk("v_tlen", v_tlen, m_act[6]);
   endtask

   // One clock cycle: drive after negedge, check decoded enables, clock, check registers
   task automatic step(input bit we, input logic [2:0] a, input logic [15:0] d,
                       input bit hd, input bit vd, input bit r);
      int div;
      cfg_we = we; cfg_addr = a; cfg_wdata = d; h_done = hd; v_done = vd; rst = r;
      #1;
      if (m_valid) begin
         div = int'(m_act[7][DIV_W-1:0]);
         chk("h_ena", {15'd0, h_ena}, {15'd0, m_running() && (m_rc % (div + 1) == 0)});
         chk("v_ena", {15'd0, v_ena}, {15'd0, m_running() && hd});
      end
      @(posedge clk);
      model_update(we, a, d, hd, vd, r);
      #1;
      if (m_valid) check_regs();
      @(negedge clk);
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      step(1'b1, a, d, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b0);
   endtask

   // Emulated cores: h_done every hper cycles, v_done on the last line; optional write on v_done
   task automatic frame(input int lines, input int hper, input bit wl,
                        input logic [2:0] wa, input logic [15:0] wd);
      for (int l = 0; l < lines; l++) begin
         for (int c = 0; c < hper; c++) begin
            bit last;
            bit hd;
            hd = (c == hper - 1);
            last = hd && (l == lines - 1);
            step(last && wl, wa, wd, hd, last, 1'b0);
         end
      end
   endtask

   initial begin
      int cnt;
      logic first;
      cfg_we = 0; cfg_addr = 0; cfg_wdata = 0; h_done = 0; v_done = 0; rst = 1;
      @(negedge clk);

      // Reset state
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      chk("rst_busy", {15'd0, busy}, 16'd0);
      chk("rst_frame_cnt", frame_cnt, 16'd0);
      chk("rst_h_ena", {15'd0, h_ena}, 16'd0);

      // Basic run
      wr(1, 16'h0102); wr(2, 16'd4); wr(3, 16'd10);
      wr(4, 16'h0101); wr(5, 16'd3); wr(6, 16'd6); wr(7, 16'd0);
      chk("pend_before_run", {15'd0, upd_pend}, 16'd1);
      wr(0, 16'd1);
      chk("core_clr_after_write", {15'd0, core_clr}, 16'd1);
      idle(1);
      chk("first_run_h_ena", {15'd0, h_ena}, 16'd1);

      // Mid-frame update
      wr(3, 16'd20);
      chk("mid_pend", {15'd0, upd_pend}, 16'd1);
      chk("mid_h_tlen_old", h_tlen, 16'd10);
      frame(6, 10, 0, 0, 0);
      chk("f1_cnt", frame_cnt, 16'd1);
      chk("f1_h_tlen_new", h_tlen, 16'd20);
      chk("f1_pend_clr", {15'd0, upd_pend}, 16'd0);

      // Write collides with apply
      wr(3, 16'd30);
      frame(6, 10, 1, 3, 16'd40);
      chk("f2_cnt", frame_cnt, 16'd2);
      chk("coll_h_tlen", h_tlen, 16'd30);
      chk("coll_pend", {15'd0, upd_pend}, 16'd1);
      frame(6, 10, 0, 0, 0);
      chk("f3_cnt", frame_cnt, 16'd3);
      chk("coll_h_tlen_next", h_tlen, 16'd40);

      // Stop mid-frame: drain until v_done, en writes ignored while draining
      wr(0, 16'd0);
      idle(2);
      wr(0, 16'd1);
      chk("drain_busy", {15'd0, busy}, 16'd1);
      frame(2, 10, 0, 0, 0);
      chk("drain_done_busy", {15'd0, busy}, 16'd0);
      idle(3);
      chk("drain_no_restart", {15'd0, busy}, 16'd0);

      // Divider: 1 of every 4 cycles, starting on the first RUN cycle
      wr(7, 16'hFFF3);
      wr(0, 16'd1);
      idle(1);
      cnt = 0;
      first = h_ena;
      for (int i = 0; i < 16; i++) begin
         cnt += int'(h_ena);
         idle(1);
      end
      chk("div_first", {15'd0, first}, 16'd1);
      chk("div_count", 16'(cnt), 16'd4);

      // Reset mid-run
      step(0, 0, 0, 0, 0, 1);
      chk("midrst_busy", {15'd0, busy}, 16'd0);
      chk("midrst_h_ena", {15'd0, h_ena}, 16'd0);
      chk("midrst_frame_cnt", frame_cnt, 16'd0);
      chk("midrst_h_tlen", h_tlen, 16'd0);

      // Single frame
      wr(0, 16'd3);
      idle(1);
      frame(3, 4, 0, 0, 0);
      chk("single_busy", {15'd0, busy}, 16'd0);
      frame(2, 4, 0, 0, 0);
      chk("single_once", frame_cnt, 16'd1);

      // Frame counter wrap
      force dut.frame_cnt = 16'hFFFF;
      #1;
      release dut.frame_cnt;
      m_frame = 16'hFFFF;
      wr(0, 16'd1);
      idle(1);
      frame(1, 3, 0, 0, 0);
      chk("wrap_zero", frame_cnt, 16'd0);
      wr(0, 16'd0);
      frame(1, 3, 0, 0, 0);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         bit we, hd, vd, r;
         logic [2:0] a;
         logic [15:0] d;
         r = ($urandom_range(0, 499) == 0);
         hd = ($urandom_range(0, 3) == 0);
         vd = hd && ($urandom_range(0, 4) == 0);
         we = ($urandom_range(0, 7) == 0);
         a = (m_mode == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 6));
         d = 16'($urandom);
         if (a == 0) d = {14'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0)};
         step(we, a, d, hd, vd, r);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
